// File: rtl/rv_registers.sv
// RV32I integer register file: 2^ADDR_WIDTH x DATA_WIDTH, two combinational read
// ports, one rising-edge write port, x0 hardwired to zero.
module rv_registers #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] rs1,
   input  logic [ADDR_WIDTH-1:0] rs2,
   input  logic [ADDR_WIDTH-1:0] rd,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  reg_write,
   output logic [DATA_WIDTH-1:0] rs1_data,
   output logic [DATA_WIDTH-1:0] rs2_data
);

   localparam int NUM_REGS = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic                  wr_en;

   // x0 is never a write target, so its flop stays at reset value and folds away.
   assign wr_en = reg_write && (rd != '0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[rd] <= data;
      end
   end

   // No bypass: a same-cycle write is seen only after the capturing edge.
   assign rs1_data = (rs1 == '0) ? '0 : regs[rs1];
   assign rs2_data = (rs2 == '0) ? '0 : regs[rs2];

endmodule

// File: tb/tb_rv_registers.sv
// Scoreboard bench for rv_registers: stimulus pushes expected read-port values,
// a separate monitor samples the ports and compares.
module tb_rv_registers;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
   logic [31:0] data = '0;
   logic        reg_write = 1'b0;
   logic [31:0] rs1_data, rs2_data;

   rv_registers dut (
      .clock(clock), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd),
      .data(data), .reg_write(reg_write), .rs1_data(rs1_data), .rs2_data(rs2_data)
   );

   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic [31:0] e1;
      logic [31:0] e2;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   event sample_ev;

   // Monitor: each sample request presents a settled output pair to compare.
   initial begin
      exp_t e;
      forever begin
         @(sample_ev);
         #1;
         if (exp_q.size() == 0) begin
            errors++; checks++;
            $display("FAIL empty_queue: sample requested with no expectation");
         end else begin
            e = exp_q.pop_front();
            checks++;
            if (rs1_data !== e.e1) begin
               errors++;
               $display("FAIL %s.rs1: got %h expected %h", e.name, rs1_data, e.e1);
            end
            checks++;
            if (rs2_data !== e.e2) begin
               errors++;
               $display("FAIL %s.rs2: got %h expected %h", e.name, rs2_data, e.e2);
            end
         end
      end
   end

   task automatic expect_ports(input string name, input logic [31:0] e1, input logic [31:0] e2);
      exp_t e;
      e.name = name; e.e1 = e1; e.e2 = e2;
      exp_q.push_back(e);
      -> sample_ev;
      #2;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic en);
      @(negedge clock);
      rd = a; data = d; reg_write = en;
      @(posedge clock);
      #1;
      reg_write = 1'b0;
   endtask

   initial begin
      // Reset / initial
      rs1 = 5'd0; rs2 = 5'd31;
      #2;
      expect_ports("reset_held", 32'h0, 32'h0);
      @(negedge clock); reset = 1'b0;
      @(negedge clock);
      expect_ports("reset_initial", 32'h0, 32'h0);

      // Basic write/read with no bypass
      @(negedge clock);
      rd = 5'd10; data = 32'd999; reg_write = 1'b1; rs1 = 5'd10; rs2 = 5'd10;
      #1;
      expect_ports("no_bypass", 32'h0, 32'h0);
      @(posedge clock); #1; reg_write = 1'b0;
      expect_ports("basic_write", 32'd999, 32'd999);

      // x0 protection
      wr(5'd0, 32'hDEADBEEF, 1'b1);
      rs1 = 5'd0; rs2 = 5'd10;
      expect_ports("x0_protect", 32'h0, 32'd999);

      // Write enable low
      wr(5'd5, 32'd123, 1'b1);
      wr(5'd5, 32'd77, 1'b0);
      rs1 = 5'd5; rs2 = 5'd0;
      expect_ports("wen_low", 32'd123, 32'h0);

      // Dual port and full width
      wr(5'd31, 32'hFFFFFFFF, 1'b1);
      wr(5'd1, 32'h80000001, 1'b1);
      rs1 = 5'd31; rs2 = 5'd1;
      expect_ports("dual_port", 32'hFFFFFFFF, 32'h80000001);
      rs2 = 5'd31;
      expect_ports("same_reg", 32'hFFFFFFFF, 32'hFFFFFFFF);

      // Async reset mid-cycle, writes blocked while held
      rs1 = 5'd10; rs2 = 5'd5;
      expect_ports("pre_reset", 32'd999, 32'd123);
      @(negedge clock); #2;
      reset = 1'b1;
      expect_ports("async_reset", 32'h0, 32'h0);
      rd = 5'd10; data = 32'd5; reg_write = 1'b1;
      @(posedge clock); #1;
      expect_ports("write_in_reset", 32'h0, 32'h0);
      @(negedge clock); reset = 1'b0; reg_write = 1'b0;
      #1;
      expect_ports("after_reset", 32'h0, 32'h0);

      // First write after deassertion
      wr(5'd10, 32'd5, 1'b1);
      expect_ports("post_reset_write", 32'd5, 32'h0);

      // Drain the scoreboard within a bounded wait
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clock);
      if (exp_q.size() != 0) begin
         errors++; checks++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      #5;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
